mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of every address bus.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the width of every data bus.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, ADDR_W), if_rdata (out, DATA_W) and if_ready (out, 1): the read-only instruction-fetch requester.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, ADDR_W), d_wdata (in, DATA_W), d_rdata (out, DATA_W) and d_ready (out, 1): the data-access requester.
REQ-007 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_rdata (in, DATA_W) and mem_ack (in, 1): the single-port memory.
REQ-008 SHALL have ports stall_f (out, 1) = if_req & ~if_ready and stall_m (out, 1) = d_req & ~d_ready, both combinational, for pipeline freeze.

Function
REQ-009 SHALL implement a state machine with states IDLE, SERVE_I and SERVE_D.
REQ-010 In IDLE with only if_req set, SHALL go to SERVE_I; with only d_req set, SHALL go to SERVE_D; with neither set, SHALL stay in IDLE.
REQ-011 In IDLE with both requests set, SHALL grant data: go to SERVE_D. REQ-026 modifies this rule.
REQ-012 On entering SERVE_x, SHALL register the requester's address, we and wdata into mem_addr, mem_we and mem_wdata; mem_we SHALL be 0 for SERVE_I.
REQ-013 SHALL assert mem_req throughout SERVE_x, starting the cycle after the request is sampled in IDLE, and hold all mem_* outputs stable until mem_ack.
REQ-014 On mem_ack in SERVE_x, SHALL capture mem_rdata into x_rdata, pulse x_ready for exactly the next cycle, deassert mem_req in that same next cycle, and return to IDLE.
REQ-015 Minimum latency SHALL be 3 cycles from sampled request to ready when mem_ack arrives in the first mem_req cycle.
REQ-016 x_rdata SHALL hold its last captured value until the next completion for that port; d_rdata SHALL also update on writes.
REQ-017 mem_ack seen outside SERVE_x SHALL be ignored.
REQ-018 A requester that drops its request mid-transaction SHALL NOT abort it; the access completes and the ready pulse still occurs.
REQ-019 A request held high through its ready cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-020 Requesters SHALL keep req, addr, we and wdata stable until ready; the arbiter SHALL NOT re-sample them during SERVE_x.

Reset
REQ-021 On rst, SHALL enter IDLE immediately, regardless of clock.
REQ-022 On rst, SHALL clear mem_req, mem_we, if_ready and d_ready to 0.
REQ-023 On rst, SHALL clear mem_addr, mem_wdata, if_rdata and d_rdata to 0.
REQ-024 On rst during SERVE_x, SHALL drop the access with no ready pulse; a later stray mem_ack SHALL be ignored (REQ-017).

Configuration
REQ-025 SHALL compile a fairness feature in or out with the macro ARB_FAIR_EN.
REQ-026 With ARB_FAIR_EN defined, SHALL keep a 1-bit last_d flag, set after a SERVE_D completion and cleared after a SERVE_I completion; on a tie in IDLE, SHALL grant SERVE_I when last_d is 1 and SERVE_D otherwise; rst SHALL clear last_d to 0.
REQ-027 Without ARB_FAIR_EN, SHALL give data strict priority on every tie and contain no last_d flag.

Verification
REQ-028 Scenario, single fetch: if_req=1, if_addr=0x10, mem_ack in the first mem_req cycle, mem_rdata=0x00500093 -> mem_req with mem_we=0, if_ready one cycle, if_rdata=0x00500093, 3-cycle latency.
REQ-029 Scenario, data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, mem_ack after 4 waits -> mem_addr=0x20 and mem_wdata=0xDEADBEEF held 5 cycles; d_ready one cycle; stall_m=1 until then.
REQ-030 Scenario, contention: if_req and d_req both held -> without ARB_FAIR_EN, data is served repeatedly and fetch waits; with ARB_FAIR_EN, grants are D,I,D,I.
REQ-031 Scenario, reset mid-operation: rst asserted during SERVE_D, then mem_ack pulses after release -> mem_req drops asynchronously; no d_ready; state IDLE.
REQ-032 Scenario, drop request: d_req deasserted after grant, mem_ack arrives later -> d_ready still pulses once; next state IDLE.
REQ-033 Scenario, stray ack: mem_ack=1 while in IDLE with no requests -> no ready pulse; all outputs unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Latency : 3 cycles minimum from the cycle a request is sampled to its ready pulse (ack in first mem_req cycle).
// Backpressure: memory stalls by withholding mem_ack; requesters see stall_f/stall_m until their one-cycle ready.
//
// Ports:
//   clk, rst                               single clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_ready    read-only fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready   data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack   single-port memory
//   stall_f, stall_m                       combinational pipeline-freeze outputs
// Build option: define ARB_FAIR_EN to alternate grants on ties (otherwise data always wins ties).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data access
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // pipeline freeze
  output logic              stall_f,
  output logic              stall_m
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_n;
  logic   grant_i, grant_d, done;
  logic   tie_to_i;

`ifdef ARB_FAIR_EN
  // Remembers which port completed last so a tie goes to the other one.
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (done) begin
      last_d <= (state == SERVE_D);
    end
  end

  assign tie_to_i = last_d;
`else
  assign tie_to_i = 1'b0;
`endif

  assign stall_f = if_req & ~if_ready;
  assign stall_m = d_req & ~d_ready;

  // Requests are only looked at in IDLE; ack is only honoured while serving,
  // so a stray ack (including one arriving after a reset) is simply ignored.
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && tie_to_i)) begin
          state_n = SERVE_D;
          grant_d = 1'b1;
        end else if (if_req) begin
          state_n = SERVE_I;
          grant_i = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ack) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Memory-side outputs are captured once at grant and then left alone, so
  // they stay stable through any number of wait cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == SERVE_I) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else begin
          // Writes also capture mem_rdata, whatever the memory returns.
          d_rdata <= mem_rdata;
          d_ready <= 1'b1;
        end
      end
    end
  end

endmodule
